// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter
//   Shares the register file's single write port between two writeback
//   requesters. A (pipeline writeback) has priority. B (a multi-cycle unit
//   such as load return) is guaranteed progress by a starvation counter.
//   Each granted write is registered and drives the one-hot bit-cell write
//   enables during the following cycle. Register 0 is hardwired to zero.
//
//   Ports
//     clk, rst             clock, asynchronous active-low reset
//     a_valid/a_ready      requester A handshake, a_addr/a_data payload
//     b_valid/b_ready      requester B handshake, b_addr/b_data payload
//     wr_en, wr_addr,      registered write strobe, address, one-hot
//     wr_sel, wr_data      per-register enable and data to the bit cells
//     wr_src               source of the current write (0 = A, 1 = B)
//     starved              high while B is being forced through
//
//   Optional feature macro: RF_WR_BYPASS_EN
//     Adds rd_addr1/rd_addr2 inputs and byp1_hit/byp2_hit/byp_data outputs
//     so the read stage can forward the value being written in the commit
//     cycle.
module rf_wr_arbiter #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [ADDR_W-1:0]    a_addr,
    input  logic [DATA_W-1:0]    a_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [ADDR_W-1:0]    b_addr,
    input  logic [DATA_W-1:0]    b_data,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [(1<<ADDR_W)-1:0] wr_sel,
    output logic [DATA_W-1:0]    wr_data,
    output logic                 wr_src,
    output logic                 starved
`ifdef RF_WR_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]    rd_addr1,
    input  logic [ADDR_W-1:0]    rd_addr2,
    output logic                 byp1_hit,
    output logic                 byp2_hit,
    output logic [DATA_W-1:0]    byp_data
`endif
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);
    localparam logic [NREG-1:0] SEL_ONE = NREG'(1);

    typedef enum logic {NORM, FORCE_B} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        a_hs, b_hs, hs;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_data;

    // Ready, next state and starvation count
    always_comb begin
        a_ready   = (state == NORM);
        b_ready   = (state == NORM) ? !a_valid : 1'b1;
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            NORM: begin
                if (!b_valid || b_ready)
                    cnt_nxt = '0;
                else if (cnt == SMAX)
                    state_nxt = FORCE_B;   // count saturates; B forced next cycle
                else
                    cnt_nxt = cnt + 4'd1;
            end
            FORCE_B: begin
                // b_ready is 1 here: either B hands off, or b_valid dropped
                // (protocol violation) and the transfer is abandoned.
                state_nxt = NORM;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = NORM;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign a_hs    = a_valid && a_ready;
    assign b_hs    = b_valid && b_ready;
    assign hs      = a_hs || b_hs;    // never both: ready logic is exclusive
    assign c_addr  = a_hs ? a_addr : b_addr;
    assign c_data  = a_hs ? a_data : b_data;
    assign starved = (state == FORCE_B);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= NORM;
            cnt     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_sel  <= '0;
            wr_data <= '0;
            wr_src  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (hs) begin
                // Writes to register 0 complete the handshake but never
                // strobe the array.
                wr_en   <= (c_addr != '0);
                wr_sel  <= (c_addr != '0) ? (SEL_ONE << c_addr) : '0;
                wr_addr <= c_addr;
                wr_data <= c_data;
                wr_src  <= b_hs;
            end else begin
                wr_en  <= 1'b0;
                wr_sel <= '0;
            end
        end
    end

`ifdef RF_WR_BYPASS_EN
    assign byp1_hit = wr_en && (rd_addr1 == wr_addr);
    assign byp2_hit = wr_en && (rd_addr2 == wr_addr);
    assign byp_data = wr_data;
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Scoreboard bench for rf_wr_arbiter: the driver predicts each accepted
// write from a policy-level model and queues it; a monitor pops and checks
// every strobe the DUT presents.
module tb_rf_wr_arbiter;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int SM = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           a_valid = 1'b0, b_valid = 1'b0;
    logic [AW-1:0]  a_addr = '0, b_addr = '0;
    logic [DW-1:0]  a_data = '0, b_data = '0;
    logic           a_ready, b_ready, wr_en, wr_src, starved;
    logic [AW-1:0]  wr_addr;
    logic [15:0]    wr_sel;
    logic [DW-1:0]  wr_data;
`ifdef RF_WR_BYPASS_EN
    logic [AW-1:0]  rd_addr1 = '0, rd_addr2 = '0;
    logic           byp1_hit, byp2_hit;
    logic [DW-1:0]  byp_data;
`endif

    rf_wr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_sel(wr_sel), .wr_data(wr_data),
        .wr_src(wr_src), .starved(starved)
`ifdef RF_WR_BYPASS_EN
        , .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .byp1_hit(byp1_hit), .byp2_hit(byp2_hit), .byp_data(byp_data)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          src;
    } exp_t;
    exp_t q[$];

    // Policy model: B is forced once it has been refused SM+1 cycles in a row.
    int            refused = 0;
    // What the write port should be showing in the current cycle.
    logic          m_en = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;

    // Monitor
    always @(negedge clk) begin
        if (rst) begin
            if (wr_en) begin
                if (q.size() == 0) begin
                    check("wr_spurious", 32'(wr_en), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("wr_cycle", 32'(cyc), 32'(e.cyc));
                    check("wr_addr", 32'(wr_addr), 32'(e.addr));
                    check("wr_data", 32'(wr_data), 32'(e.data));
                    check("wr_src", 32'(wr_src), 32'(e.src));
                    check("wr_sel", 32'(wr_sel), 32'(1) << e.addr);
                end
            end else begin
                check("wr_sel_idle", 32'(wr_sel), 32'd0);
                if (q.size() > 0 && q[0].cyc <= cyc) begin
                    check("wr_missing", 32'(wr_en), 32'd1);
                    void'(q.pop_front());
                end
            end
        end
    end

    // One cycle of stimulus: drive at the falling edge, check readies a
    // little later, and queue any write the model says was accepted.
    task automatic step(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                        output logic b_acc);
        logic forced, ea, eb, a_acc;
        exp_t e;
        @(negedge clk);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
`ifdef RF_WR_BYPASS_EN
        rd_addr1 = ($urandom_range(0, 1) == 1) ? m_addr : AW'($urandom);
        rd_addr2 = AW'($urandom);
`endif
        #1;
        forced = (refused == SM + 1);
        ea = !forced;
        eb = forced ? 1'b1 : !av;
        check("a_ready", 32'(a_ready), 32'(ea));
        check("b_ready", 32'(b_ready), 32'(eb));
        check("starved", 32'(starved), 32'(forced));
`ifdef RF_WR_BYPASS_EN
        check("byp1_hit", 32'(byp1_hit), 32'(m_en && rd_addr1 == m_addr));
        check("byp2_hit", 32'(byp2_hit), 32'(m_en && rd_addr2 == m_addr));
        check("byp_data", 32'(byp_data), 32'(m_data));
`endif
        a_acc = av && ea;
        b_acc = bv && eb;
        m_en = 1'b0;
        if (a_acc || b_acc) begin
            e.cyc  = cyc + 1;
            e.addr = a_acc ? aa : ba;
            e.data = a_acc ? ad : bd;
            e.src  = b_acc;
            if (e.addr != 0) q.push_back(e);
            m_en   = (e.addr != 0);
            m_addr = e.addr;
            m_data = e.data;
        end
        refused = (bv && !b_acc) ? refused + 1 : 0;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, acc);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_wr_en"}, 32'(wr_en), 0);
        check({nm, "_wr_addr"}, 32'(wr_addr), 0);
        check({nm, "_wr_sel"}, 32'(wr_sel), 0);
        check({nm, "_wr_data"}, 32'(wr_data), 0);
        check({nm, "_wr_src"}, 32'(wr_src), 0);
        check({nm, "_starved"}, 32'(starved), 0);
    endtask

    initial begin
        logic acc;
        logic b_pend;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        int guard;

        #3;
        check_all_zero("reset");
        @(posedge clk); @(posedge clk);
        #2 rst = 1'b1;

        // first write after reset: addr 5 -> wr_sel bit 5
        step(1, 4'd5, 16'hBEEF, 0, '0, '0, acc);
        idle(1);

        // priority: A wins, B lands the next cycle
        step(1, 4'd3, 16'h0A03, 1, 4'd7, 16'h0B07, acc);
        check("prio_b_refused", 32'(acc), 0);
        step(0, '0, '0, 1, 4'd7, 16'h0B07, acc);
        check("prio_b_taken", 32'(acc), 1);
        idle(1);

        // starvation: A valid every cycle
        acc = 1'b0;
        guard = 0;
        while (!acc && guard < 10) begin
            step(1, AW'($urandom_range(1, 15)), DW'($urandom), 1, 4'd9, 16'h5A5A, acc);
            guard++;
        end
        check("starve_wait", 32'(guard), 32'(SM + 2));
        step(1, 4'd2, 16'h2222, 0, '0, '0, acc);
        idle(1);

        // register 0 never strobes
        step(1, 4'd0, 16'hFFFF, 0, '0, '0, acc);
        idle(2);

        // back-to-back A writes, addr 1..15
        for (int i = 1; i < 16; i++) step(1, AW'(i), DW'(16'h1000 + i), 0, '0, '0, acc);
        idle(1);

        // bypass directed case (commit of addr 9 is visible next cycle)
        step(1, 4'd9, 16'h1234, 0, '0, '0, acc);
        idle(1);

        // reset while a write is on the port
        step(1, 4'd12, 16'hC0DE, 0, '0, '0, acc);
        @(posedge clk); #1;
        check("pre_rst_wr_en", 32'(wr_en), 1);
        rst = 1'b0;
        a_valid = 1'b0;
        #1;
        check_all_zero("midrst");
        q.delete();
        refused = 0;
        m_en = 1'b0; m_addr = '0; m_data = '0;
        @(negedge clk);
        @(posedge clk); #2 rst = 1'b1;

        // randomized traffic; B holds its request until accepted
        b_pend = 1'b0; pa = '0; pd = '0;
        for (int i = 0; i < 1500; i++) begin
            if (!b_pend && $urandom_range(0, 2) == 0) begin
                b_pend = 1'b1;
                pa = AW'($urandom);
                pd = DW'($urandom);
            end
            step($urandom_range(0, 3) != 0, AW'($urandom), DW'($urandom), b_pend, pa, pd, acc);
            if (acc) b_pend = 1'b0;
        end
        idle(3);
        check("queue_drained", 32'(q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
